// File: rtl/req_arbiter8.sv
// req_arbiter8: 8-requester arbiter with a registered one-hot grant.
//   Policy is fixed priority (bit 7 highest) or round-robin, chosen by `mode`
//   at each arbitration. An optional hold limit reclaims the resource from a
//   requester that keeps it for MAX_HOLD consecutive busy cycles.
//
// Parameters
//   MAX_HOLD  max consecutive BUSY cycles per grant, 0 = unlimited (0..255)
//   HOLD_W    hold counter width, 2**HOLD_W must exceed MAX_HOLD
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[7:0]   level request vector, bit i = requester i
//   mode       0 = fixed priority, 1 = round-robin
//   gnt[7:0]   registered one-hot grant, zero when idle
//   gnt_id     index of the granted requester, 0 when no grant
//   gnt_valid  high while a grant is held
//   preempt    one-cycle pulse when a grant is revoked by hold timeout
//
// state | meaning
// IDLE  | no grant; arbitrate among pending requests on each edge
// BUSY  | grant held; watch for release or hold timeout

module req_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       mode,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {IDLE, BUSY} state_t;

  // For MAX_HOLD=0 this value is unused; timeout is gated by the parameter.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [2:0]        last_q, last_d;
  logic [7:0]        gnt_d;
  logic [2:0]        id_d;
  logic              valid_d, preempt_d;
  logic [2:0]        win_fixed, win_rr, win;
  logic              timeout;

  // Fixed priority: ascending scan so the highest set bit is the last write.
  always_comb begin
    win_fixed = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) win_fixed = 3'(i);
    end
  end

  // Round-robin: candidates are last-1, last-2, ... last-8 (= last itself).
  // Scanning from the lowest-priority offset down lets the nearest one win.
  always_comb begin
    win_rr = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      if (req[last_q - 3'(k)]) win_rr = last_q - 3'(k);
    end
  end

  assign win     = mode ? win_rr : win_fixed;
  assign timeout = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    gnt_d     = gnt;
    id_d      = gnt_id;
    valid_d   = gnt_valid;
    preempt_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          gnt_d   = 8'd1 << win;
          id_d    = win;
          valid_d = 1'b1;
          cnt_d   = '0;
          last_d  = win;
        end
      end
      BUSY: begin
        if (!req[gnt_id] || timeout) begin
          state_d   = IDLE;
          gnt_d     = 8'd0;
          id_d      = 3'd0;
          valid_d   = 1'b0;
          preempt_d = req[gnt_id];
        end else if (cnt_q != {HOLD_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 3'd0;
      gnt       <= 8'd0;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt       <= gnt_d;
      gnt_id    <= id_d;
      gnt_valid <= valid_d;
      preempt   <= preempt_d;
    end
  end

endmodule

// File: tb/tb_req_arbiter8.sv
module tb_req_arbiter8;

  localparam int LIM [3] = '{16, 4, 0};

  logic             clk;
  logic             rst_n;
  logic             mode;
  logic [2:0][7:0]  req_v;
  logic [2:0][7:0]  gnt_o;
  logic [2:0][2:0]  id_o;
  logic [2:0]       val_o;
  logic [2:0]       pre_o;

  int checks;
  int failures;
  bit mon_en;

  req_arbiter8 #(.MAX_HOLD(16), .HOLD_W(8)) u16 (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]), .mode(mode),
    .gnt(gnt_o[0]), .gnt_id(id_o[0]), .gnt_valid(val_o[0]), .preempt(pre_o[0]));
  req_arbiter8 #(.MAX_HOLD(4), .HOLD_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]), .mode(mode),
    .gnt(gnt_o[1]), .gnt_id(id_o[1]), .gnt_valid(val_o[1]), .preempt(pre_o[1]));
  req_arbiter8 #(.MAX_HOLD(0), .HOLD_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req_v[2]), .mode(mode),
    .gnt(gnt_o[2]), .gnt_id(id_o[2]), .gnt_valid(val_o[2]), .preempt(pre_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who holds the resource, for how many cycles it has held
  // it, who won last, and whether the last revoke was a timeout.
  bit m_busy [3];
  int m_id   [3];
  int m_last [3];
  int m_held [3];
  bit m_pre  [3];

  function automatic int pick(input logic [7:0] r, input logic md, input int last);
    if (!md) begin
      for (int i = 7; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= 8; k++) begin
        int idx;
        idx = (last - k + 8) % 8;
        if (r[idx]) return idx;
      end
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_busy[k] <= 1'b0; m_id[k] <= 0; m_last[k] <= 0; m_held[k] <= 0; m_pre[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_pre[k] <= 1'b0;
        if (!m_busy[k]) begin
          if (req_v[k] != 8'd0) begin
            m_busy[k] <= 1'b1;
            m_id[k]   <= pick(req_v[k], mode, m_last[k]);
            m_last[k] <= pick(req_v[k], mode, m_last[k]);
            m_held[k] <= 1;
          end
        end else if (!req_v[k][m_id[k]]) begin
          m_busy[k] <= 1'b0;
        end else if (LIM[k] != 0 && m_held[k] == LIM[k]) begin
          m_busy[k] <= 1'b0;
          m_pre[k]  <= 1'b1;
        end else begin
          m_held[k] <= m_held[k] + 1;
        end
      end
    end
  end

  // Structural invariants on every instance, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (!(gnt_o[k] == 8'd0 || $onehot(gnt_o[k]))) begin
          failures++;
          $display("FAIL inv_onehot[%0d]: gnt=%b not one-hot or zero", k, gnt_o[k]);
        end
        checks++;
        if (val_o[k] !== (|gnt_o[k])) begin
          failures++;
          $display("FAIL inv_valid[%0d]: gnt_valid=%b gnt=%b", k, val_o[k], gnt_o[k]);
        end
        if (val_o[k]) begin
          checks++;
          if (gnt_o[k] !== (8'd1 << id_o[k])) begin
            failures++;
            $display("FAIL inv_id[%0d]: gnt=%b gnt_id=%0d", k, gnt_o[k], id_o[k]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    mode  = 1'b0;
    req_v = '0;
    #2 rst_n = 1'b0;
    #20;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (gnt_o[k] !== 8'd0 || val_o[k] !== 1'b0 || id_o[k] !== 3'd0 || pre_o[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: gnt=%b valid=%b id=%0d pre=%b want all zero",
                 k, gnt_o[k], val_o[k], id_o[k], pre_o[k]);
      end
    end
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (gnt_o[k] !== 8'd0 || val_o[k] !== 1'b0 || id_o[k] !== 3'd0 || pre_o[k] !== 1'b0) begin
          failures++;
          $display("FAIL reset_idle[%0d] cyc %0d: gnt=%b valid=%b id=%0d pre=%b want all zero",
                   k, c, gnt_o[k], val_o[k], id_o[k], pre_o[k]);
        end
      end
    end
  endtask

  task automatic test_fixed();
    mode = 1'b0;
    req_v[0] = 8'b0010_0110;
    step();
    checks++;
    if (gnt_o[0] !== 8'b0010_0000 || id_o[0] !== 3'd5) begin
      failures++;
      $display("FAIL fixed_first: gnt=%b id=%0d want 00100000 id=5", gnt_o[0], id_o[0]);
    end
    req_v[0] = 8'b0000_0110;
    step();
    checks++;
    if (gnt_o[0] !== 8'd0) begin
      failures++;
      $display("FAIL fixed_gap1: gnt=%b want 0", gnt_o[0]);
    end
    step();
    checks++;
    if (id_o[0] !== 3'd2 || val_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL fixed_second: id=%0d valid=%b want id=2 valid=1", id_o[0], val_o[0]);
    end
    req_v[0] = 8'b0000_0010;
    step();
    checks++;
    if (gnt_o[0] !== 8'd0) begin
      failures++;
      $display("FAIL fixed_gap2: gnt=%b want 0", gnt_o[0]);
    end
    step();
    checks++;
    if (id_o[0] !== 3'd1 || val_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL fixed_third: id=%0d valid=%b want id=1 valid=1", id_o[0], val_o[0]);
    end
    req_v[0] = 8'd0;
    step(); step();
  endtask

  task automatic test_round_robin();
    do_reset();
    mode = 1'b1;
    req_v[0] = 8'hFF;
    for (int n = 0; n < 10; n++) begin
      int exp_id;
      exp_id = 7 - (n % 8);
      step();
      checks++;
      if (val_o[0] !== 1'b1 || id_o[0] !== 3'(exp_id)) begin
        failures++;
        $display("FAIL rr_grant #%0d: id=%0d valid=%b want id=%0d", n, id_o[0], val_o[0], exp_id);
      end
      req_v[0] = 8'hFF & ~(8'd1 << exp_id);
      step();
      checks++;
      if (gnt_o[0] !== 8'd0) begin
        failures++;
        $display("FAIL rr_gap #%0d: gnt=%b want 0", n, gnt_o[0]);
      end
      req_v[0] = 8'hFF;
    end
    req_v[0] = 8'd0;
    step(); step(); step();
  endtask

  task automatic test_timeout(input logic md, input int regrant_id);
    do_reset();
    mode = md;
    req_v[1] = 8'b1000_0001;
    step();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (val_o[1] !== 1'b1 || id_o[1] !== 3'd7 || pre_o[1] !== 1'b0) begin
        failures++;
        $display("FAIL timeout_hold m%0d cyc %0d: valid=%b id=%0d pre=%b want valid=1 id=7 pre=0",
                 md, c, val_o[1], id_o[1], pre_o[1]);
      end
      step();
    end
    checks++;
    if (val_o[1] !== 1'b0 || pre_o[1] !== 1'b1) begin
      failures++;
      $display("FAIL timeout_revoke m%0d: valid=%b pre=%b want valid=0 pre=1", md, val_o[1], pre_o[1]);
    end
    step();
    checks++;
    if (val_o[1] !== 1'b1 || id_o[1] !== 3'(regrant_id) || pre_o[1] !== 1'b0) begin
      failures++;
      $display("FAIL timeout_regrant m%0d: valid=%b id=%0d pre=%b want valid=1 id=%0d pre=0",
               md, val_o[1], id_o[1], pre_o[1], regrant_id);
    end
    req_v[1] = 8'd0;
    step(); step();
  endtask

  task automatic test_async_reset();
    do_reset();
    mode = 1'b0;
    req_v[0] = 8'h08;
    step();
    checks++;
    if (id_o[0] !== 3'd3 || val_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL areset_setup: id=%0d valid=%b want id=3 valid=1", id_o[0], val_o[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (gnt_o[0] !== 8'd0 || val_o[0] !== 1'b0 || id_o[0] !== 3'd0) begin
      failures++;
      $display("FAIL areset_clear: gnt=%b valid=%b id=%0d want all zero before edge",
               gnt_o[0], val_o[0], id_o[0]);
    end
    #1 rst_n = 1'b1;
    step();
    checks++;
    if (id_o[0] !== 3'd3 || val_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL areset_regrant: id=%0d valid=%b want id=3 valid=1", id_o[0], val_o[0]);
    end
    req_v[0] = 8'd0;
    step(); step();
  endtask

  task automatic test_unlimited();
    int bad;
    do_reset();
    mode = 1'b0;
    req_v[2] = 8'h04;
    step();
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      req_v[2] = 8'h04 | ($urandom_range(0, 1) == 1 ? 8'h40 : 8'h00);
      step();
      checks++;
      if (val_o[2] !== 1'b1 || id_o[2] !== 3'd2 || pre_o[2] !== 1'b0) begin
        failures++;
        if (bad < 5)
          $display("FAIL unlimited_hold cyc %0d: valid=%b id=%0d pre=%b want valid=1 id=2 pre=0",
                   c, val_o[2], id_o[2], pre_o[2]);
        bad++;
      end
    end
    req_v[2] = 8'h40;
    step();
    checks++;
    if (gnt_o[2] !== 8'd0 || pre_o[2] !== 1'b0) begin
      failures++;
      $display("FAIL unlimited_gap: gnt=%b pre=%b want 0 0", gnt_o[2], pre_o[2]);
    end
    step();
    checks++;
    if (id_o[2] !== 3'd6 || val_o[2] !== 1'b1) begin
      failures++;
      $display("FAIL unlimited_next: id=%0d valid=%b want id=6 valid=1", id_o[2], val_o[2]);
    end
    req_v[2] = 8'd0;
    step(); step();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0)
          req_v[k] = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      end
      mode = 1'($urandom_range(0, 1));
      step();
      for (int k = 0; k < 3; k++) begin
        logic [7:0] exp_g;
        logic [2:0] exp_id;
        exp_g  = m_busy[k] ? (8'd1 << m_id[k]) : 8'd0;
        exp_id = m_busy[k] ? 3'(m_id[k]) : 3'd0;
        checks++;
        if (gnt_o[k] !== exp_g || id_o[k] !== exp_id || val_o[k] !== m_busy[k]
            || pre_o[k] !== m_pre[k]) begin
          failures++;
          if (bad < 10)
            $display("FAIL random[%0d] cyc %0d: gnt=%b id=%0d valid=%b pre=%b want gnt=%b id=%0d valid=%b pre=%b",
                     k, c, gnt_o[k], id_o[k], val_o[k], pre_o[k], exp_g, exp_id, m_busy[k], m_pre[k]);
          bad++;
        end
      end
    end
    req_v = '0;
    step(); step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_timeout(1'b0, 7);
    test_timeout(1'b1, 0);
    test_async_reset();
    test_unlimited();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/req_arbiter8.md
Name: req_arbiter8

Overview:
- 8-requester arbiter for a shared resource (bus/datapath port).
- Resolves concurrent requests to a single registered one-hot grant plus 3-bit grant index, using the same bit-7-highest encoding as the team's 8-to-3 priority encoder.
- Runtime-selectable fixed-priority or round-robin policy.
- Optional hold-time limit forcibly reclaims the resource from a requester that holds it too long.

Parameters:
- MAX_HOLD, 16, max consecutive BUSY cycles per grant; 0 = unlimited; legal range 0..255.
- HOLD_W, 8, width of internal hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i = requester i; level-sensitive, held high while resource wanted.
- mode  input  1  0 = fixed priority (bit 7 highest), 1 = round-robin; sampled only at arbitration.
- gnt  output  8  registered one-hot grant; all-zero when idle.
- gnt_id  output  3  index of granted requester; valid only when gnt_valid=1, else 3'b000.
- gnt_valid  output  1  high while a grant is held (state BUSY).
- preempt  output  1  one-cycle pulse on the cycle a grant is revoked by hold timeout.

Behaviour:
- Reset (rst_n low, asynchronous, any state, mid-grant included): state=IDLE, gnt=0, gnt_id=0, gnt_valid=0, preempt=0, hold counter=0, last_id=0. Outputs clear immediately, without waiting for clk.
- All outputs are registered; no combinational path from req to gnt.
- FSM states: IDLE, BUSY.
- IDLE:
  - gnt=0, gnt_valid=0.
  - If req≠0 at a rising edge: pick winner W, go to BUSY. On that edge, gnt=1<<W, gnt_id=W, gnt_valid=1, counter=0, last_id=W.
  - Latency: grant visible one clock after req is first sampled high.
  - If req=0: stay in IDLE.
- Winner selection, mode=0: highest-index set bit of req.
- Winner selection, mode=1:
  - Scan descending from (last_id−1) mod 8, wrapping 0→7. First set bit wins.
  - The previous winner therefore gets lowest priority.
  - After reset, last_id=0, so the scan starts at 7 and matches fixed priority.
- BUSY, at each rising edge, in priority order:
  - (a) req[gnt_id]=0 (voluntary release): go to IDLE, clear gnt/gnt_id/gnt_valid, preempt=0.
  - (b) Else if MAX_HOLD≠0 and counter=MAX_HOLD−1 (timeout): go to IDLE, clear grant, preempt=1 for exactly one cycle.
  - (c) Else: stay in BUSY, counter+1, grant unchanged.
- Exactly MAX_HOLD BUSY cycles at most per grant.
- Counter saturates at all-ones when MAX_HOLD=0; it never wraps.
- Mandatory one-cycle idle gap between consecutive grants (gnt=0 for ≥1 cycle). No back-to-back handover and no overlapping grants.
- Requests from non-holders during BUSY are ignored. They are re-evaluated in the IDLE gap cycle.
- A preempted requester still asserting req may re-win in the gap:
  - mode=0: it re-wins if it is highest priority.
  - mode=1: it has lowest priority, but still wins if it is the sole requester.
- Changes on mode during BUSY have no effect until the next arbitration.
- Invariants checked by the bench:
  - gnt is one-hot or zero.
  - gnt==(1<<gnt_id) whenever gnt_valid=1.
  - gnt_valid==|gnt.

Test Plan:
- Reset/idle: hold rst_n=0, then release with req=0 for 5 cycles -> gnt=0, gnt_valid=0, gnt_id=0, preempt=0 throughout.
- Fixed priority: mode=0, req=8'b0010_0110 for 1 edge -> next cycle gnt=8'b0010_0000, gnt_id=5. Then drop req[5] -> gnt=0 for 1 cycle. Next grant is gnt_id=2, then gnt_id=1.
- Round-robin fairness: mode=1, req=8'hFF held, each holder drops its bit 1 cycle after grant and reasserts in the gap -> grant order 7,6,5,4,3,2,1,0,7,…, with a 1-cycle gnt=0 gap between each.
- Hold timeout: MAX_HOLD=4, mode=0, req=8'b1000_0001 held -> gnt_id=7 for exactly 4 cycles, preempt=1 on the revoke cycle, 1 gap cycle, then gnt_id=7 again. Repeat with mode=1 -> after the gap, gnt_id=0.
- Asynchronous reset mid-grant: grant gnt_id=3 active, pulse rst_n low between clock edges -> gnt, gnt_valid, gnt_id clear before the next edge. After release with req=8'h08 held, grant returns 1 cycle after the first edge.
- Unlimited hold/ignore others: MAX_HOLD=0, req[2] held 300 cycles while req[6] toggles -> gnt_id=2 continuously, counter does not wrap, preempt never asserts. On req[2] drop -> gap cycle, then gnt_id=6 if req[6]=1.
